// File: rtl/cyclic_encoder_ctrl.sv
// Serial systematic cyclic (CRC-style) encoder: accepts a K-bit message, streams it
// MSB first followed by the P parity bits of m(x)*x^P mod g(x), with valid/ready flow control.
module cyclic_encoder_ctrl #(
  parameter int N = 15,
  parameter int K = 11,
  parameter logic [N-K:0] GEN = 5'b10011
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] msg_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_bit,
  output logic         out_sop,
  output logic         out_eop,
  output logic         busy
);

  localparam int P  = N - K;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [K-1:0]  msg_q, msg_d;
  logic [P-1:0]  par_q, par_d;
  logic [IW-1:0] idx_q, idx_d;

  logic accept;
  logic xfer;
  logic fb;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  // The latched message shifts left per data transfer, so its MSB is always the current bit.
  assign fb = msg_q[K-1] ^ par_q[P-1];

  always_comb begin
    out_bit = 1'b0;
    case (state_q)
      DATA:    out_bit = msg_q[K-1];
      PARITY:  out_bit = par_q[P-1];
      default: out_bit = 1'b0;
    endcase
  end

  assign out_sop = (state_q == DATA)   && (idx_q == '0);
  assign out_eop = (state_q == PARITY) && (idx_q == IW'(N - 1));

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    par_d   = par_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          msg_d   = msg_data;
          par_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          msg_d = msg_q << 1;
          par_d = (par_q << 1) ^ (fb ? GEN[P-1:0] : {P{1'b0}});
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(K - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (xfer) begin
          par_d = par_q << 1;
          if (idx_q == IW'(N - 1)) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      msg_q   <= '0;
      par_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      par_q   <= par_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: doc/cyclic_encoder_ctrl.md
CYCLIC_ENCODER_CTRL -- requirements
Module: cyclic_encoder_ctrl

Interface
REQ-001 Parameter N, default 15, codeword length in bits.
REQ-002 Parameter K, default 11, message length in bits; N-K = parity length P.
REQ-003 Parameter GEN, default 5'b10011, generator polynomial g(x) coefficients, width P+1, MSB = x^P term (x^4+x+1).
REQ-004 Port list (clock and reset first):
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  msg_data valid.
- in_ready  output  1  controller can accept a message.
- msg_data  input  K  message; bit K-1 = highest-order coefficient, sent first.
- out_valid  output  1  out_bit holds a valid codeword bit.
- out_ready  input  1  downstream accepts out_bit this cycle.
- out_bit  output  1  serial systematic codeword bit.
- out_sop  output  1  out_bit is codeword bit N-1 (first).
- out_eop  output  1  out_bit is codeword bit 0 (last).
- busy  output  1  high whenever state is not IDLE.

Function
REQ-005 The controller SHALL implement states IDLE, DATA and PARITY.
REQ-006 Handshake rules:
- A message SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1.
- in_ready SHALL be 1 exactly in IDLE.
- A bit SHALL transfer only on a rising edge with out_valid=1 and out_ready=1.
REQ-007 On acceptance, the controller SHALL latch msg_data, clear the parity register (P bits), set the bit index to 0 and enter DATA. out_valid SHALL be 1 from the next cycle, with out_bit=msg_data[K-1] and out_sop=1.
REQ-008 DATA SHALL present message bits MSB first, one per transfer, for K transfers.
REQ-009 On each DATA transfer of bit b, the parity register r SHALL update as follows:
- fb = b XOR r[P-1];
- r <= (r<<1) XOR (fb ? GEN[P-1:0] : 0).
REQ-010 After the K-th DATA transfer, the controller SHALL enter PARITY. r then equals m(x)*x^P mod g(x).
REQ-011 PARITY SHALL present r MSB first for P transfers, shifting r left by one per transfer. After the N-th total transfer the controller SHALL return to IDLE.
REQ-012 out_eop SHALL be 1 only on the N-th bit of the frame. out_sop and out_eop SHALL never both be 1 when N>1.
REQ-013 While out_valid=1 and out_ready=0, out_bit, out_sop, out_eop, r, the index and the state SHALL hold unchanged for any number of cycles.
REQ-014 out_valid SHALL be 0 in IDLE. There is no bubble inside a frame: out_valid stays 1 from the first bit through the last transfer.
REQ-015 There SHALL be exactly one idle cycle (in_ready=1) between the last transfer of a frame and the first bit of the next frame. in_valid held high SHALL be accepted in that cycle.
REQ-016 While busy, in_valid SHALL be ignored and msg_data changes SHALL have no effect on the frame in progress.
REQ-017 The bit index SHALL be wide enough to count to N-1 with no wrap-around inside a frame. It SHALL restart at 0 on every acceptance.

Reset
REQ-018 When rst_n=0, the controller SHALL immediately, asynchronously, enter IDLE and set:
- r=0, index=0, latched message=0;
- out_valid=0, out_bit=0, out_sop=0, out_eop=0, busy=0, in_ready=1.
REQ-019 A reset during a frame SHALL abandon that frame with no further output bits. After rst_n returns high, the next accepted message SHALL start a fresh frame.
REQ-020 Reset release SHALL take effect on the first rising clk edge with rst_n=1.

Verification
REQ-021 msg_data=11'b00000000001, out_ready=1 constantly -> 15 consecutive bits 000000000010011; out_sop on the first bit, out_eop on the 15th.
REQ-022 msg_data=11'b10000000000 -> bits 100000000001001 (parity 1001). msg_data=0 -> 15 zero bits with correct sop/eop.
REQ-023 Backpressure: the REQ-021 message with out_ready toggling pseudo-randomly (0 for up to 5 cycles) -> the same 15-bit sequence with no bit duplicated or lost. Outputs are stable during every stall.
REQ-024 Back-to-back: in_valid held 1 with the two messages of REQ-021 then REQ-022 -> two complete frames separated by exactly one out_valid=0 cycle. msg_data changes mid-frame do not alter the first frame.
REQ-025 Reset mid-frame: assert rst_n=0 between clock edges after the 6th bit transfers -> out_valid=0 and in_ready=1 immediately. After release, message 11'b00000000001 yields 000000000010011.
REQ-026 Scoreboard: 1000 random messages with random out_ready -> every frame equals {m, m(x)*x^4 mod g(x)} from a reference model, and every codeword is divisible by g(x).
